// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per cycle.
module md_div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_next_o,
    output logic [WIDTH-1:0] rem_next_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted, diff;

    // Top bit of diff is the borrow: set means the trial subtract must be undone.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            rem_next_o = diff[WIDTH-1:0];
            quo_next_o = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_o = shifted[WIDTH-1:0];
            quo_next_o = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_next_o;
            quo_q <= quo_next_o;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers and flush support.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic             Cancel,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               is_div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q, prod_d, mul_step, mul_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   a_abs, b_abs, quo_next, rem_next;
    logic               accept, op_signed, op_div, op_mul, b_zero;

    assign Busy      = (state_q == StRun);
    assign Done      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign accept    = Start & ~Busy & ~Cancel;
    assign op_signed = (MDOp == MD_MULT) || (MDOp == MD_DIV);
    assign op_div    = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
    assign op_mul    = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
    assign b_zero    = (SrcB == '0);
    assign a_abs     = abs_val(SrcA, op_signed);
    assign b_abs     = abs_val(SrcB, op_signed);

    md_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk_i      (clk),
        .load_i     (accept & op_div),
        .step_i     (Busy & is_div_q),
        .dividend_i (a_abs),
        .divisor_i  (b_abs),
        .quo_next_o (quo_next),
        .rem_next_o (rem_next)
    );

    // Multiplier sits in the low half of prod_q and is consumed LSB first.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
        mul_step = {mul_sum, prod_q[WIDTH-1:1]};
        mul_res  = neg_res_q ? -mul_step : mul_step;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (MDOp)
                        MD_MTHI: hi_d = SrcA;
                        MD_MTLO: lo_d = SrcA;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            state_d = StRun;
                            cnt_d   = CNT_W'(WIDTH);
                            prod_d  = {{WIDTH{1'b0}}, b_abs};
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                prod_d = mul_step;
                cnt_d  = cnt_q - CNT_W'(1);
                if (Cancel) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -quo_next : quo_next;
                        hi_d = neg_rem_q ? -rem_next : rem_next;
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            prod_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
            if (accept && (op_div || op_mul)) begin
                is_div_q  <= op_div;
                // Divide-by-zero keeps the raw all-ones quotient unnegated.
                neg_res_q <= op_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) & ~(op_div & b_zero);
                neg_rem_q <= op_signed & SrcA[WIDTH-1];
                mcand_q   <= a_abs;
            end
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers. Sits beside the combinational ALU in the EX stage.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles, and MTHI/MTLO in a single cycle.
- Exposes Busy so the hazard unit stalls MFHI/MFLO and further MD ops.
- Accepts a Cancel from exception flush, so a faulting instruction never commits HI/LO.

Parameters:
- WIDTH, 32, operand width and HI/LO width; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request an MD op this cycle.
- MDOp  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Cancel  input  1  flush: abort an in-flight op, or suppress a same-cycle Start.
- SrcA  input  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
- SrcB  input  WIDTH  multiplier/divisor.
- Busy  output  1  iterative op in progress.
- Done  output  1  one-cycle pulse: new HI/LO from an iterative op are visible.
- HI  output  WIDTH  high product / remainder.
- LO  output  WIDTH  low product / quotient.

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, Busy=0, Done=0, counter=0, state IDLE. Reset overrides Start and Cancel in the same cycle. Reset mid-operation aborts the op; results are discarded.
- States: IDLE, RUN.
- Acceptance: a Start is accepted when Start & ~Busy & ~Cancel in cycle T.
  - Start while Busy: ignored entirely, including MTHI/MTLO.
  - Unknown MDOp encoding: ignored.
- MTHI/MTLO accepted in T: HI (or LO) <= SrcA at the end of T. Busy stays 0 and no Done pulse.
- MULT/MULTU/DIV/DIVU accepted in T:
  - Operands are latched; signed ops latch the absolute values plus the result signs.
  - Go to RUN with counter=WIDTH.
  - Busy=1 in cycles T+1 .. T+WIDTH.
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - At the end of T+WIDTH: HI/LO written with sign-corrected results, state returns to IDLE.
  - In T+WIDTH+1: Busy=0, Done=1 for exactly one cycle. Total latency is WIDTH+1 cycles from Start to result visible.
- Multiply results: {HI,LO} = full 2*WIDTH product. Signed for MULT, unsigned for MULTU.
- Divide results: LO = quotient, truncated toward zero; HI = remainder, with sign equal to the dividend's.
  - DIV of most-negative value by -1: LO = most-negative value, HI = 0. No exception.
  - Divide by zero (DIV or DIVU): LO = all ones, HI = SrcA unchanged. Same latency.
- Cancel:
  - While in RUN: return to IDLE at the end of that cycle. HI/LO keep their pre-op values, Busy=0 next cycle, no Done.
  - In the final RUN cycle (T+WIDTH): also wins, so HI/LO are not written.
  - While IDLE with no Start: no effect.
- HI/LO are not modified during RUN; intermediate results live in internal registers only.
- Back-to-back: a new Start is accepted in the Done cycle (T+WIDTH+1).

Decomposition:
- MD op encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5) belong in the shared macro header, next to the ALU control codes.
- Sign/absolute-value helpers stay local to the block.
- One natural sub-module: md_div_core, an unsigned WIDTH-bit restoring divider step datapath (remainder/quotient registers plus one subtract per cycle). Multiply stays inline in mult_div_unit.

Test Plan:
- MULT SrcA=0xFFFFFFFD (-3), SrcB=7 -> Busy high 32 cycles; Done at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- MULTU SrcA=0xFFFFFFFF, SrcB=2 -> HI=0x00000001, LO=0xFFFFFFFE. Then MTHI 0x12345678 in the Done cycle -> HI=0x12345678 next cycle, LO unchanged, no Busy.
- DIV SrcA=0xFFFFFFF9 (-7), SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU SrcA=7, SrcB=0 -> LO=0xFFFFFFFF, HI=0x00000007, latency 33 cycles.
- Preload HI=0xA, LO=0xB. Start DIVU 100/3, Cancel at RUN cycle 10 -> Busy=0 next cycle, no Done, HI=0xA, LO=0xB. A second Start issued during RUN is ignored. Cancel asserted with Start -> nothing starts.
- Reset asserted mid-MULT -> next cycle Busy=0, Done=0, HI=LO=0. A Start after reset completes normally.
